// File: rtl/rename_if.sv
// Decode-to-rename bundle: two decoded instructions plus retire frees in,
// stall and two renamed instructions out.
interface rename_if;
    logic [6:0]  instr1_opcode, instr2_opcode;
    logic [4:0]  instr1_rs1, instr1_rs2, instr1_rd;
    logic [4:0]  instr2_rs1, instr2_rs2, instr2_rd;
    logic [31:0] instr1_imm, instr2_imm;
    logic [6:0]  instr1_funct7, instr2_funct7;
    logic [2:0]  instr1_funct3, instr2_funct3;
    logic [5:0]  free_reg1, free_reg2;
    logic        stall;
    logic [6:0]  o1_opcode, o2_opcode;
    logic [31:0] o1_imm, o2_imm;
    logic [6:0]  o1_funct7, o2_funct7;
    logic [2:0]  o1_funct3, o2_funct3;
    logic [5:0]  o1_p_rs1, o1_p_rs2, o1_p_rd, o1_p_old_rd;
    logic [5:0]  o2_p_rs1, o2_p_rs2, o2_p_rd, o2_p_old_rd;

    modport master (
        output instr1_opcode, instr1_rs1, instr1_rs2, instr1_rd, instr1_imm, instr1_funct7, instr1_funct3,
        output instr2_opcode, instr2_rs1, instr2_rs2, instr2_rd, instr2_imm, instr2_funct7, instr2_funct3,
        output free_reg1, free_reg2,
        input  stall,
        input  o1_opcode, o1_imm, o1_funct7, o1_funct3, o1_p_rs1, o1_p_rs2, o1_p_rd, o1_p_old_rd,
        input  o2_opcode, o2_imm, o2_funct7, o2_funct3, o2_p_rs1, o2_p_rs2, o2_p_rd, o2_p_old_rd
    );
    modport slave (
        input  instr1_opcode, instr1_rs1, instr1_rs2, instr1_rd, instr1_imm, instr1_funct7, instr1_funct3,
        input  instr2_opcode, instr2_rs1, instr2_rs2, instr2_rd, instr2_imm, instr2_funct7, instr2_funct3,
        input  free_reg1, free_reg2,
        output stall,
        output o1_opcode, o1_imm, o1_funct7, o1_funct3, o1_p_rs1, o1_p_rs2, o1_p_rd, o1_p_old_rd,
        output o2_opcode, o2_imm, o2_funct7, o2_funct3, o2_p_rs1, o2_p_rs2, o2_p_rd, o2_p_old_rd
    );
endinterface

// File: rtl/rename_unit.sv
// 2-wide register rename with circular free list; one-cycle latency.
// stall is combinational and all-or-nothing: a stalled pair emits bubbles and leaves the RAT untouched.
module rename_unit #(
    parameter int PREG_COUNT = 64,
    parameter int AREG_COUNT = 32
) (
    input  logic    clk,
    input  logic    reset,
    rename_if.slave io
);
    localparam int PW = $clog2(PREG_COUNT);
    localparam logic [6:0] OP_SW = 7'b0100011;

    typedef struct packed {
        logic [6:0]    opcode;
        logic [31:0]   imm;
        logic [6:0]    funct7;
        logic [2:0]    funct3;
        logic [PW-1:0] p_rs1;
        logic [PW-1:0] p_rs2;
        logic [PW-1:0] p_rd;
        logic [PW-1:0] p_old_rd;
    } ren_t;

    logic [PW-1:0] rat [AREG_COUNT];
    logic [PW-1:0] fl  [PREG_COUNT];
    logic [PW-1:0] head, tail, tail2;
    logic [PW:0]   free_count;
    ren_t          o1_q, o2_q, o1_d, o2_d;
    logic          alloc1, alloc2;
    logic [1:0]    need, rets, grant;
    logic [PW-1:0] new1, new2;

    assign alloc1 = (io.instr1_opcode != '0) && (io.instr1_opcode != OP_SW) && (io.instr1_rd != '0);
    assign alloc2 = (io.instr2_opcode != '0) && (io.instr2_opcode != OP_SW) && (io.instr2_rd != '0);
    assign need   = {1'b0, alloc1} + {1'b0, alloc2};
    // Frees arriving this cycle are deliberately not counted toward this cycle's budget.
    assign io.stall = ((PW+1)'(need) > free_count);
    assign grant  = io.stall ? 2'd0 : need;
    assign new1   = fl[head];
    assign new2   = alloc1 ? fl[head + PW'(1)] : fl[head];
    assign rets   = {1'b0, io.free_reg1 != '0} + {1'b0, io.free_reg2 != '0};
    assign tail2  = (io.free_reg1 != '0) ? tail + PW'(1) : tail;

    always_comb begin
        o1_d = '0;
        o2_d = '0;
        if (!io.stall) begin
            if (io.instr1_opcode != '0) begin
                o1_d.opcode = io.instr1_opcode;
                o1_d.imm    = io.instr1_imm;
                o1_d.funct7 = io.instr1_funct7;
                o1_d.funct3 = io.instr1_funct3;
                o1_d.p_rs1  = rat[io.instr1_rs1];
                o1_d.p_rs2  = rat[io.instr1_rs2];
                if (alloc1) begin
                    o1_d.p_rd     = new1;
                    o1_d.p_old_rd = rat[io.instr1_rd];
                end
            end
            // instr2 sees instr1's fresh mapping as if the two were renamed in order.
            if (io.instr2_opcode != '0) begin
                o2_d.opcode = io.instr2_opcode;
                o2_d.imm    = io.instr2_imm;
                o2_d.funct7 = io.instr2_funct7;
                o2_d.funct3 = io.instr2_funct3;
                o2_d.p_rs1  = (alloc1 && io.instr2_rs1 == io.instr1_rd) ? new1 : rat[io.instr2_rs1];
                o2_d.p_rs2  = (alloc1 && io.instr2_rs2 == io.instr1_rd) ? new1 : rat[io.instr2_rs2];
                if (alloc2) begin
                    o2_d.p_rd     = new2;
                    o2_d.p_old_rd = (alloc1 && io.instr2_rd == io.instr1_rd) ? new1 : rat[io.instr2_rd];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < AREG_COUNT; i++) rat[i] <= PW'(i);
            for (int i = 0; i < PREG_COUNT; i++)
                fl[i] <= (i < PREG_COUNT - AREG_COUNT) ? PW'(AREG_COUNT + i) : '0;
            head       <= '0;
            tail       <= PW'(PREG_COUNT - AREG_COUNT);
            free_count <= (PW+1)'(PREG_COUNT - AREG_COUNT);
            o1_q       <= '0;
            o2_q       <= '0;
        end else begin
            o1_q <= o1_d;
            o2_q <= o2_d;
            if (!io.stall) begin
                if (alloc1) rat[io.instr1_rd] <= new1;
                if (alloc2) rat[io.instr2_rd] <= new2;
            end
            if (io.free_reg1 != '0) fl[tail]  <= io.free_reg1;
            if (io.free_reg2 != '0) fl[tail2] <= io.free_reg2;
            head       <= head + PW'(grant);
            tail       <= tail + PW'(rets);
            free_count <= free_count + (PW+1)'(rets) - (PW+1)'(grant);
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        (32'(free_count) + 32'(rets)) <= PREG_COUNT - 1);

    assign io.o1_opcode   = o1_q.opcode;
    assign io.o1_imm      = o1_q.imm;
    assign io.o1_funct7   = o1_q.funct7;
    assign io.o1_funct3   = o1_q.funct3;
    assign io.o1_p_rs1    = o1_q.p_rs1;
    assign io.o1_p_rs2    = o1_q.p_rs2;
    assign io.o1_p_rd     = o1_q.p_rd;
    assign io.o1_p_old_rd = o1_q.p_old_rd;
    assign io.o2_opcode   = o2_q.opcode;
    assign io.o2_imm      = o2_q.imm;
    assign io.o2_funct7   = o2_q.funct7;
    assign io.o2_funct3   = o2_q.funct3;
    assign io.o2_p_rs1    = o2_q.p_rs1;
    assign io.o2_p_rs2    = o2_q.p_rs2;
    assign io.o2_p_rd     = o2_q.p_rd;
    assign io.o2_p_old_rd = o2_q.p_old_rd;
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage for the 2-wide pipeline. Sits between the instruction decoder and the reservation station.
- Maps 5-bit architectural registers of up to two decoded instructions per cycle to 6-bit physical registers. Allocates new physical destinations from a free list and reports the previous mapping (old_rd) for later release.
- Reclaims physical registers returned by the retire logic through free_reg1/free_reg2.

Parameters:
- PREG_COUNT, 64, number of physical registers; p0 is hardwired zero and never allocated.
- AREG_COUNT, 32, number of architectural registers.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instrN_opcode  in  7  decoded opcode (N=1,2); 0 = bubble
- instrN_rs1, instrN_rs2, instrN_rd  in  5 each  architectural registers
- instrN_imm  in  32  immediate, passed through
- instrN_funct7  in  7  passed through
- instrN_funct3  in  3  passed through
- free_reg1, free_reg2  in  6 each  physical registers released by retire; 0 = none
- stall  out  1  combinational; upstream must hold both instructions while high
- oN_opcode, oN_imm, oN_funct7, oN_funct3  out  7/32/7/3  registered pass-through
- oN_p_rs1, oN_p_rs2, oN_p_rd, oN_p_old_rd  out  6 each  registered physical mappings

Behaviour:
- Reset (async, active-high):
  - RAT[i]=i for i=0..31.
  - Free list FIFO holds p32..p63 in ascending order; head=0, tail=32 (mod 64), count=32.
  - All registered outputs = 0, i.e. bubbles.
  - Reset mid-operation discards any in-flight pair.
- Allocation request: instrN allocates iff opcode!=0, opcode!=sw (7'b0100011), and rd!=0. need = alloc1 + alloc2 (0..2).
- stall = (need > count), evaluated against count at the start of the cycle. Same-cycle frees are not bypassed.
- Renaming is all-or-nothing. When stall=1:
  - Neither instruction is renamed; the RAT is unchanged.
  - Outputs are bubbles next cycle (all fields 0).
- Latency: one cycle from inputs to oN_* outputs.
- Sources:
  - oN_p_rs1 = RAT[rs1], oN_p_rs2 = RAT[rs2].
  - Architectural x0 always maps to p0.
  - For instr2 only: if alloc1 and instr2_rsK == instr1_rd, use instr1's newly allocated register instead of RAT.
- Destinations:
  - alloc1 takes the head entry, alloc2 takes the next entry (or the head entry if alloc1=0).
  - p_old_rd = RAT[rd] before the update.
  - If both instructions write the same rd: o2_p_old_rd = o1_p_rd, and the final RAT[rd] = o2_p_rd.
  - Non-allocating instructions output p_rd=0 and p_old_rd=0. Sources are still mapped.
- Bubble instruction (opcode 0): all outputs 0. The other slot is renamed normally.
- Free list:
  - Circular, 64 entries, 6-bit head/tail with wrap-around, 7-bit count.
  - Returns are enqueued free_reg1 first, then free_reg2. A value of 0 is ignored.
  - Next count = count + returns − allocations, with simultaneous alloc and free in the same cycle.
  - A returned register is allocatable from the next cycle.
- count never exceeds 63. A return that would exceed 63 is a design error, flagged by assertion in simulation.
- No flush or branch recovery: the pipeline has no branches.

Test Plan:
- Reset, then add x5,x1,x2 + addi x6,x5,4 → o1: p_rd=32, p_old_rd=5, p_rs1=1, p_rs2=2; o2: p_rd=33, p_old_rd=6, p_rs1=32 (intra-pair bypass); count=30.
- Pair both writing x7 → o1 p_rd=32, o1_p_old_rd=7; o2 p_rd=33, o2_p_old_rd=32; a later read of x7 maps to 33.
- sw x3,0(x4) + add x0,x1,x1 → no allocation, both p_rd=0, count unchanged at 32, stall=0.
- Allocate 16 pairs (count=0), then present an allocating pair → stall=1 and bubble outputs. Drive free_reg1=40, free_reg2=41 → next cycle count=2, stall=0, allocations are 40 then 41.
- count=1 with two allocating instructions → stall=1 (all-or-nothing); with only instr1 allocating → renamed, count=0. A same-cycle free_reg1=50 gives count=1 after the edge.
- Assert reset mid-stream after 5 allocations → outputs 0 immediately, RAT identity, count=32, first post-reset allocation is p32.
